// File: rtl/pattern_sequencer.sv
// pattern_sequencer: 16-step, 4-channel programmable note sequencer.
// Holds a writable pattern memory, steps through it at a fixed tempo and
// drives per-channel notes/gates plus a free-running note_clk.
//
// state | meaning
// IDLE  | not playing; gates forced low, notes hold last values
// PLAY  | stepping through pattern, one step every STEP_CYCLES clocks
module pattern_sequencer #(
    parameter int STEP_CYCLES  = 6000000,
    parameter int NOTE_CLK_DIV = 390625,
    parameter int NOTE_W       = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [3:0]        pat_len,
    input  logic              wr_en,
    input  logic [3:0]        wr_step,
    input  logic [1:0]        wr_ch,
    input  logic [NOTE_W-1:0] wr_note,
    input  logic              wr_gate,
    output logic [NOTE_W-1:0] note_ch0,
    output logic [NOTE_W-1:0] note_ch1,
    output logic [NOTE_W-1:0] note_ch2,
    output logic [NOTE_W-1:0] note_ch3,
    output logic [3:0]        gate,
    output logic [3:0]        step_idx,
    output logic              step_tick,
    output logic              busy,
    output logic              done,
    output logic              note_clk
);

    localparam int SC_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam int NC_W = (NOTE_CLK_DIV > 2) ? $clog2(NOTE_CLK_DIV) : 1;
    localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEP_CYCLES - 1);
    localparam logic [NC_W-1:0] DIV_LAST  = NC_W'(NOTE_CLK_DIV - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t            state;
    logic [SC_W-1:0]   step_cnt;
    logic [NC_W-1:0]   div_cnt;
    logic [3:0]        len_r;
    logic [NOTE_W-1:0] note_r   [4];
    logic [NOTE_W-1:0] mem_note [16][4];
    logic              mem_gate [16][4];

    logic [3:0]        next_idx;
    logic [NOTE_W-1:0] ld_note  [4];
    logic [3:0]        ld_gate;

    assign note_ch0 = note_r[0];
    assign note_ch1 = note_r[1];
    assign note_ch2 = note_r[2];
    assign note_ch3 = note_r[3];

    // Step to be loaded on the next load event, read with write-through so a
    // same-cycle write to that entry reaches the outputs immediately.
    always_comb begin
        next_idx = 4'd0;
        if (!start && (step_idx < len_r))
            next_idx = step_idx + 4'd1;
        for (int c = 0; c < 4; c++) begin
            ld_note[c] = mem_note[next_idx][c];
            ld_gate[c] = mem_gate[next_idx][c];
            if (wr_en && (wr_step == next_idx) && (wr_ch == 2'(c))) begin
                ld_note[c] = wr_note;
                ld_gate[c] = wr_gate;
            end
        end
    end

    // Pattern memory: single-cycle write port, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < 16; s++) begin
                for (int c = 0; c < 4; c++) begin
                    mem_note[s][c] <= '0;
                    mem_gate[s][c] <= 1'b0;
                end
            end
        end else if (wr_en) begin
            mem_note[wr_step][wr_ch] <= wr_note;
            mem_gate[wr_step][wr_ch] <= wr_gate;
        end
    end

    // Free-running note_clk divider, toggles on each counter wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            note_clk <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            note_clk <= ~note_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Playback FSM: stop > start > step boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            step_cnt  <= '0;
            len_r     <= 4'd0;
            step_idx  <= 4'd0;
            gate      <= 4'd0;
            step_tick <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int c = 0; c < 4; c++) note_r[c] <= '0;
        end else begin
            step_tick <= 1'b0;
            done      <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                busy     <= 1'b0;
                gate     <= 4'd0;
                step_cnt <= '0;
            end else if (start) begin
                state     <= PLAY;
                busy      <= 1'b1;
                len_r     <= pat_len;
                step_idx  <= 4'd0;
                step_cnt  <= '0;
                step_tick <= 1'b1;
                gate      <= ld_gate;
                for (int c = 0; c < 4; c++) note_r[c] <= ld_note[c];
            end else if (state == PLAY) begin
                if (step_cnt == STEP_LAST) begin
                    step_cnt <= '0;
                    if ((step_idx < len_r) || loop_en) begin
                        step_idx  <= next_idx;
                        step_tick <= 1'b1;
                        gate      <= ld_gate;
                        for (int c = 0; c < 4; c++) note_r[c] <= ld_note[c];
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        gate  <= 4'd0;
                        done  <= 1'b1;
                    end
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed testbench for pattern_sequencer (STEP_CYCLES=4, NOTE_CLK_DIV=3).
module tb_pattern_sequencer;

    localparam int NW = 6;

    logic          clk = 1'b0;
    logic          rst_n, start, stop, loop_en, wr_en, wr_gate;
    logic [3:0]    pat_len, wr_step;
    logic [1:0]    wr_ch;
    logic [NW-1:0] wr_note;
    logic [NW-1:0] note_ch0, note_ch1, note_ch2, note_ch3;
    logic [3:0]    gate, step_idx;
    logic          step_tick, busy, done, note_clk;

    int passed = 0;
    int total  = 0;

    pattern_sequencer #(.STEP_CYCLES(4), .NOTE_CLK_DIV(3), .NOTE_W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .pat_len(pat_len), .wr_en(wr_en), .wr_step(wr_step), .wr_ch(wr_ch),
        .wr_note(wr_note), .wr_gate(wr_gate),
        .note_ch0(note_ch0), .note_ch1(note_ch1), .note_ch2(note_ch2), .note_ch3(note_ch3),
        .gate(gate), .step_idx(step_idx), .step_tick(step_tick), .busy(busy),
        .done(done), .note_clk(note_clk)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Advance n rising edges, then settle at the following falling edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_mem(input logic [3:0] s, input logic [1:0] c,
                             input logic [NW-1:0] n, input logic g);
        wr_en = 1'b1; wr_step = s; wr_ch = c; wr_note = n; wr_gate = g;
        wait_cycles(1);
        wr_en = 1'b0;
    endtask

    // start sampled at edge t; returns observing cycle t+1.
    task automatic pulse_start;
        start = 1'b1;
        wait_cycles(1);
        start = 1'b0;
    endtask

    task automatic test_reset;
        logic exp_clk [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rst_n = 1'b0;
        wait_cycles(3);
        total++;
        if ({note_ch0, note_ch1, note_ch2, note_ch3} !== '0) $display("FAIL reset_notes: got %h want 0", {note_ch0, note_ch1, note_ch2, note_ch3});
        else passed++;
        total++;
        if ({gate, step_idx, step_tick, busy, done, note_clk} !== 12'h000)
            $display("FAIL reset_ctrl: gate=%b idx=%0d tick=%b busy=%b done=%b nclk=%b want all 0", gate, step_idx, step_tick, busy, done, note_clk);
        else passed++;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_cycles(1);
            total++;
            if (note_clk !== exp_clk[k]) $display("FAIL note_clk[%0d]: got %b want %b", k, note_clk, exp_clk[k]);
            else passed++;
        end
    endtask

    task automatic test_basic;
        write_mem(4'd0, 2'd0, 6'd41, 1'b1);
        write_mem(4'd1, 2'd0, 6'd46, 1'b0);
        pat_len = 4'd1; loop_en = 1'b0;
        pulse_start;
        total++;
        if (note_ch0 !== 6'd41 || gate !== 4'b0001 || step_tick !== 1'b1 || busy !== 1'b1 || step_idx !== 4'd0)
            $display("FAIL basic_t1: note=%0d gate=%b tick=%b busy=%b idx=%0d want 41 0001 1 1 0", note_ch0, gate, step_tick, busy, step_idx);
        else passed++;
        wait_cycles(1);
        total++;
        if (step_tick !== 1'b0) $display("FAIL basic_tick_pulse: got %b want 0", step_tick);
        else passed++;
        wait_cycles(3);
        total++;
        if (note_ch0 !== 6'd46 || gate !== 4'b0000 || step_idx !== 4'd1 || step_tick !== 1'b1)
            $display("FAIL basic_t5: note=%0d gate=%b idx=%0d tick=%b want 46 0000 1 1", note_ch0, gate, step_idx, step_tick);
        else passed++;
        wait_cycles(3);
        total++;
        if (done !== 1'b0 || busy !== 1'b1) $display("FAIL basic_t8: done=%b busy=%b want 0 1", done, busy);
        else passed++;
        wait_cycles(1);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || step_idx !== 4'd1 || gate !== 4'b0000 || note_ch0 !== 6'd46)
            $display("FAIL basic_t9: done=%b busy=%b idx=%0d gate=%b note=%0d want 1 0 1 0000 46", done, busy, step_idx, gate, note_ch0);
        else passed++;
        wait_cycles(1);
        total++;
        if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done);
        else passed++;
    endtask

    task automatic test_loop;
        loop_en = 1'b1;
        pulse_start;
        wait_cycles(8);
        total++;
        if (step_idx !== 4'd0 || note_ch0 !== 6'd41 || step_tick !== 1'b1 || done !== 1'b0 || busy !== 1'b1)
            $display("FAIL loop_wrap: idx=%0d note=%0d tick=%b done=%b busy=%b want 0 41 1 0 1", step_idx, note_ch0, step_tick, done, busy);
        else passed++;
        loop_en = 1'b0;
        wait_cycles(8);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL loop_finish: done=%b busy=%b want 1 0", done, busy);
        else passed++;
        wait_cycles(1);
    endtask

    task automatic test_stop_start;
        loop_en = 1'b1; pat_len = 4'd1;
        pulse_start;
        wait_cycles(2);
        start = 1'b1; stop = 1'b1;
        wait_cycles(1);
        start = 1'b0; stop = 1'b0;
        total++;
        if (busy !== 1'b0 || gate !== 4'b0000 || done !== 1'b0 || step_tick !== 1'b0)
            $display("FAIL stop_collide: busy=%b gate=%b done=%b tick=%b want 0 0000 0 0", busy, gate, done, step_tick);
        else passed++;
        wait_cycles(5);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL stop_stays_idle: busy=%b done=%b want 0 0", busy, done);
        else passed++;
        pulse_start;
        wait_cycles(3);
        start = 1'b1;
        wait_cycles(1);
        start = 1'b0;
        total++;
        if (step_idx !== 4'd0 || step_tick !== 1'b1 || note_ch0 !== 6'd41)
            $display("FAIL start_at_boundary: idx=%0d tick=%b note=%0d want 0 1 41", step_idx, step_tick, note_ch0);
        else passed++;
        wait_cycles(4);
        total++;
        if (step_idx !== 4'd1 || note_ch0 !== 6'd46) $display("FAIL restart_timing: idx=%0d note=%0d want 1 46", step_idx, note_ch0);
        else passed++;
        stop = 1'b1;
        wait_cycles(1);
        stop = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL stop_at_step: busy=%b done=%b want 0 0", busy, done);
        else passed++;
    endtask

    task automatic test_write_through;
        pat_len = 4'd2; loop_en = 1'b0;
        pulse_start;
        wait_cycles(7);
        wr_en = 1'b1; wr_step = 4'd2; wr_ch = 2'd3; wr_note = 6'd20; wr_gate = 1'b1;
        wait_cycles(1);
        wr_en = 1'b0;
        total++;
        if (step_idx !== 4'd2 || note_ch3 !== 6'd20 || gate !== 4'b1000 || note_ch0 !== 6'd0)
            $display("FAIL write_through: idx=%0d n3=%0d gate=%b n0=%0d want 2 20 1000 0", step_idx, note_ch3, gate, note_ch0);
        else passed++;
        wait_cycles(4);
        total++;
        if (done !== 1'b1) $display("FAIL wt_finish: done=%b want 1", done);
        else passed++;
    endtask

    task automatic test_reset_mid;
        pat_len = 4'd2; loop_en = 1'b0;
        pulse_start;
        wait_cycles(4);
        total++;
        if (step_idx !== 4'd1 || note_ch0 !== 6'd46) $display("FAIL mid_pre: idx=%0d note=%0d want 1 46", step_idx, note_ch0);
        else passed++;
        rst_n = 1'b0;
        wait_cycles(1);
        total++;
        if (note_ch0 !== 6'd0 || gate !== 4'd0 || busy !== 1'b0 || step_idx !== 4'd0 || done !== 1'b0 || note_clk !== 1'b0)
            $display("FAIL mid_reset: note=%0d gate=%b busy=%b idx=%0d done=%b nclk=%b want all 0", note_ch0, gate, busy, step_idx, done, note_clk);
        else passed++;
        rst_n = 1'b1;
        pat_len = 4'd2;
        pulse_start;
        total++;
        if (note_ch0 !== 6'd0 || gate !== 4'd0 || busy !== 1'b1) $display("FAIL replay_s0: note=%0d gate=%b busy=%b want 0 0000 1", note_ch0, gate, busy);
        else passed++;
        wait_cycles(4);
        total++;
        if (note_ch0 !== 6'd0 || step_idx !== 4'd1) $display("FAIL replay_s1: note=%0d idx=%0d want 0 1", note_ch0, step_idx);
        else passed++;
        wait_cycles(4);
        total++;
        if (note_ch3 !== 6'd0 || gate !== 4'd0 || step_idx !== 4'd2) $display("FAIL replay_s2: n3=%0d gate=%b idx=%0d want 0 0000 2", note_ch3, gate, step_idx);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; pat_len = 4'd0;
        wr_en = 1'b0; wr_step = 4'd0; wr_ch = 2'd0; wr_note = '0; wr_gate = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_loop;
        test_stop_start;
        test_write_through;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
